// File: rtl/mem_port_sched.sv
// Single-port memory scheduler: serialises each core step's instruction fetch
// and optional load/store onto one shared memory port, and holds the core in
// stall until the step's results are ready.
module mem_port_sched #(
  parameter int          MEM_LAT = 1,
  parameter int          CNT_W   = 16,
  parameter logic [31:0] NOP     = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      i_iaddr,
  output logic [31:0]      o_inst,
  input  logic             i_dren,
  input  logic             i_dwen,
  input  logic [31:0]      i_daddr,
  input  logic [31:0]      i_dwdata,
  output logic [31:0]      o_drdata,
  output logic             o_exstall,
  output logic [31:0]      o_mem_addr,
  output logic             o_mem_ren,
  output logic             o_mem_wen,
  output logic [31:0]      o_mem_wdata,
  input  logic [31:0]      i_mem_rdata,
  output logic [CNT_W-1:0] o_stall_cnt
);

  // Wait counter holds MEM_LAT-1 down to 0; zero marks the capture cycle.
  localparam int               LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, FWAIT, DRD, DWAIT, DWR, RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             drd_setup_q, drd_setup_d;
  logic             dren_q, dren_d;
  logic             dwen_q, dwen_d;
  logic [31:0]      daddr_q, daddr_d;
  logic [31:0]      dwdata_q, dwdata_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      drdata_q, drdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state, capture and counter logic for one core step.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    drd_setup_d = drd_setup_q;
    dren_d      = dren_q;
    dwen_d      = dwen_q;
    daddr_d     = daddr_q;
    dwdata_d    = dwdata_q;
    inst_d      = inst_q;
    drdata_d    = drdata_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        // The core only presents a new request once it has advanced, so the
        // data request is sampled here and nowhere else in the step.
        dren_d   = i_dren;
        dwen_d   = i_dwen;
        daddr_d  = i_daddr;
        dwdata_d = i_dwdata;
        lat_d    = LAT_LOAD;
        state_d  = FWAIT;
      end
      FWAIT: begin
        if (lat_q == '0) begin
          inst_d = i_mem_rdata;
          if (dwen_q) begin
            state_d = DWR;               // a store wins over a simultaneous load
          end else if (dren_q) begin
            state_d     = DRD;
            drd_setup_d = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      DRD: begin
        // A load spends one address-setup cycle before its read strobe, which
        // gives the 4+2*MEM_LAT load step.
        if (drd_setup_q) begin
          drd_setup_d = 1'b0;
        end else begin
          lat_d   = LAT_LOAD;
          state_d = DWAIT;
        end
      end
      DWAIT: begin
        if (lat_q == '0) begin
          drdata_d = i_mem_rdata;
          state_d  = RELEASE;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      DWR:     state_d = RELEASE;
      RELEASE: state_d = FETCH;
      default: state_d = IDLE;
    endcase
    cnt_d = (o_exstall && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;
  end

  // Control state and results, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      drd_setup_q <= 1'b0;
      dren_q      <= 1'b0;
      dwen_q      <= 1'b0;
      inst_q      <= NOP;
      drdata_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      drd_setup_q <= drd_setup_d;
      dren_q      <= dren_d;
      dwen_q      <= dwen_d;
      inst_q      <= inst_d;
      drdata_q    <= drdata_d;
      cnt_q       <= cnt_d;
    end
  end

  // Latched data address and store data; only consumed after FETCH reloads them.
  always_ff @(posedge clk) begin
    daddr_q  <= daddr_d;
    dwdata_q <= dwdata_d;
  end

  // Memory port decode. The fetch address passes straight through in FETCH
  // because the core's new address is only valid once it has advanced.
  assign o_exstall   = (state_q != RELEASE);
  assign o_mem_ren   = (state_q == FETCH) || ((state_q == DRD) && !drd_setup_q);
  assign o_mem_wen   = (state_q == DWR);
  assign o_mem_addr  = (state_q == FETCH) ? i_iaddr :
                       ((state_q == DRD) || (state_q == DWR)) ? daddr_q : 32'h0;
  assign o_mem_wdata = (state_q == DWR) ? dwdata_q : 32'h0;
  assign o_inst      = inst_q;
  assign o_drdata    = drdata_q;
  assign o_stall_cnt = cnt_q;

endmodule
